// File: rtl/race_logic_pkg.sv
// Shared definitions for race-logic stages and their binary readout.
//   dec_state_t     : first-pulse decoder state
//   GAMMA_DEFAULT   : default aclk cycles per gamma cycle
//   infinity_code() : "no spike" time encoding, equal to the gamma cycle length
package race_logic_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, DONE} dec_state_t;

  localparam int GAMMA_DEFAULT = 16;

  function automatic int infinity_code(input int gamma);
    return gamma;
  endfunction

endpackage

// File: rtl/gamma_counter.sv
// Gamma-cycle index counter with end-of-cycle strobe.
//   aclk : clock (posedge)
//   grst : synchronous active-high reset; next cycle is index 0
//   gcnt : current cycle index 0..GAMMA_CYCLE_WIDTH-1
//   eoc  : high while gcnt is the last index of the gamma cycle
module gamma_counter #(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  localparam int CW = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  output logic [CW-1:0] gcnt,
  output logic          eoc
);

  localparam logic [CW-1:0] LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  assign eoc = (gcnt == LAST);

  always_ff @(posedge aclk) begin
    if (grst)     gcnt <= '0;
    else if (eoc) gcnt <= '0;
    else          gcnt <= gcnt + CW'(1);
  end

endmodule

// File: rtl/pulse_time_decoder.sv
// Measures the first pulse of each gamma cycle on pulse_in (onset index and
// width in aclk cycles) and publishes it over a valid/ready handshake.
//   aclk      : clock (posedge)
//   grst      : synchronous active-high reset, also restarts the gamma cycle
//   pulse_in  : pulse-width-coded spike
//   ready     : consumer accepts result when valid && ready
//   rise_time : onset index, GAMMA_CYCLE_WIDTH when no spike
//   width     : pulse width in cycles, 0 when no spike
//   no_spike  : no onset this cycle
//   truncated : pulse still high at end of cycle
//   valid     : result available, held stable until accepted
//   overrun   : sticky, a result was dropped while the previous one was pending
module pulse_time_decoder
  import race_logic_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          pulse_in,
  input  logic          ready,
  output logic [TW-1:0] rise_time,
  output logic [TW-1:0] width,
  output logic          no_spike,
  output logic          truncated,
  output logic          valid,
  output logic          overrun
);

  localparam int          CW  = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0] INF = TW'(infinity_code(GAMMA_CYCLE_WIDTH));

  logic [CW-1:0] gcnt;
  logic          eoc;
  logic          prev;
  dec_state_t    state, st_n;
  logic [TW-1:0] rise_q, rise_n;
  logic [TW-1:0] wcnt, wcnt_n;

  gamma_counter #(.GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)) u_gcnt (
    .aclk (aclk),
    .grst (grst),
    .gcnt (gcnt),
    .eoc  (eoc)
  );

  // Effect of the current sample; at EOC this is also what gets published.
  always_comb begin
    st_n   = state;
    rise_n = rise_q;
    wcnt_n = wcnt;
    case (state)
      IDLE: if (pulse_in && !prev) begin
        st_n   = HIGH;
        rise_n = TW'(gcnt);
        wcnt_n = TW'(1);
      end
      HIGH: if (pulse_in) wcnt_n = (wcnt == INF) ? wcnt : wcnt + TW'(1);
            else          st_n   = DONE;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state     <= IDLE;
      prev      <= 1'b0;
      rise_q    <= '0;
      wcnt      <= '0;
      rise_time <= '0;
      width     <= '0;
      no_spike  <= 1'b0;
      truncated <= 1'b0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // prev cleared at EOC so a pulse high at index 0 counts as an onset.
      prev <= eoc ? 1'b0 : pulse_in;
      if (eoc) begin
        state  <= IDLE;
        rise_q <= '0;
        wcnt   <= '0;
      end else begin
        state  <= st_n;
        rise_q <= rise_n;
        wcnt   <= wcnt_n;
      end

      if (eoc) begin
        // A pending result is never overwritten; the new one is dropped.
        if (!valid || ready) begin
          valid <= 1'b1;
          case (st_n)
            IDLE: begin
              rise_time <= INF;
              width     <= '0;
              no_spike  <= 1'b1;
              truncated <= 1'b0;
            end
            HIGH: begin
              rise_time <= rise_n;
              width     <= wcnt_n;
              no_spike  <= 1'b0;
              truncated <= 1'b1;
            end
            default: begin
              rise_time <= rise_n;
              width     <= wcnt_n;
              no_spike  <= 1'b0;
              truncated <= 1'b0;
            end
          endcase
        end else begin
          overrun <= 1'b1;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
